// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single-port
// data memory. Each transaction walks IDLE -> ACCESS -> RESP, three cycles
// total. Grants are combinational in IDLE; the memory strobe fires for one
// cycle in ACCESS. The response pulse goes to the winner in RESP.
module dmem_arbiter #(
  parameter int unsigned ADDR_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  // requester 0 (CPU load/store)
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  // requester 1 (debug/loader)
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  // data memory side
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Highest word-aligned address that still fits entirely in the memory.
  localparam logic [31:0] LAST_WORD = 32'(ADDR_BYTES - 4);

  state_t      state_q;
  logic        last_q;      // id of the requester served most recently
  logic        win_q;       // id of the requester owning the current transaction
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        any_req;
  logic        win_d;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic        grant_en;
  logic        rvalid_en;

  // Round-robin pick of the winner and a mux of its request fields.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    any_req   = m0_req | m1_req;
    win_d     = 1'b0;
    if (m0_req && m1_req) begin
      win_d = ~last_q;
    end else if (m1_req) begin
      win_d = 1'b1;
    end
    sel_we    = win_d ? m1_we    : m0_we;
    sel_addr  = win_d ? m1_addr  : m0_addr;
    sel_wdata = win_d ? m1_wdata : m0_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
  end

  // Strobes and pulses are gated by rst so an in-flight access is dropped
  // on the very edge reset is seen; a pending store never reaches memory.
  assign grant_en  = (state_q == IDLE) && !rst && any_req;
  assign rvalid_en = (state_q == RESP) && !rst;

  assign m0_gnt    = grant_en && !win_d;
  assign m1_gnt    = grant_en &&  win_d;

  assign m0_rvalid = rvalid_en && !win_q;
  assign m1_rvalid = rvalid_en &&  win_q;
  assign m0_rdata  = m0_rvalid ? rdata_q : 32'h0;
  assign m1_rdata  = m1_rvalid ? rdata_q : 32'h0;
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;

  assign mem_read  = (state_q == ACCESS) && !rst && !err_q && !we_q;
  assign mem_write = (state_q == ACCESS) && !rst && !err_q &&  we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Transaction FSM: latch the winner, capture load data, then respond.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q       <= win_d;
            we_q        <= sel_we;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            err_q       <= sel_err;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= (!we_q && !err_q) ? mem_rdata : 32'h0;
          state_q <= RESP;
        end
        RESP: begin
          last_q  <= win_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Expected responses are queued when a
// request is granted and popped by a monitor when an rvalid pulse appears.
// A bench-side RAM answers the memory port; a separate model array holds
// the data each load is expected to return.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ram       [1024];
  logic [31:0] model_mem [1024];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Bench memory: combinational read, write on the strobe.
  assign mem_rdata = ram[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr[11:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Queue the response a granted request should produce, updating the model.
  task automatic push(input bit id, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit err);
    exp_t e;
    e.id    = id;
    e.err   = err;
    e.rdata = 32'h0;
    if (!err) begin
      if (we) model_mem[addr[11:2]] = wdata;
      else    e.rdata = model_mem[addr[11:2]];
    end
    sb.push_back(e);
  endtask

  task automatic drive(input bit id, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (id) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  // One complete single-requester transaction, checked cycle by cycle.
  task automatic txn(input bit id, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit err);
    nxt();
    drive(id, 1'b1, we, addr, wdata);
    #1;
    check("gnt_win",   id ? m1_gnt : m0_gnt, 32'd1);
    check("gnt_other", id ? m0_gnt : m1_gnt, 32'd0);
    push(id, we, addr, wdata, err);
    nxt();
    drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("acc_read",  mem_read,  {31'd0, !we && !err});
    check("acc_write", mem_write, {31'd0,  we && !err});
    check("acc_addr",  mem_addr,  addr);
    check("acc_wdata", mem_wdata, wdata);
    check("acc_nognt", m0_gnt | m1_gnt, 32'd0);
    nxt();
    #1;
    check("resp_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("resp_addr_hold", mem_addr, addr);
  endtask

  // Response monitor: every rvalid pulse must match the oldest queued entry.
  always @(negedge clk) begin
    #2;
    if (m0_rvalid || m1_rvalid) begin
      check("rvalid_excl", {31'd0, m0_rvalid & m1_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rv_id",    {31'd0, m1_rvalid}, {31'd0, e.id});
        check("rv_rdata", e.id ? m1_rdata : m0_rdata, e.rdata);
        check("rv_err",   {31'd0, e.id ? m1_err : m0_err}, {31'd0, e.err});
        check("rv_other_zero", e.id ? {m0_rdata[30:0], m0_err} : {m1_rdata[30:0], m1_err}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]       = 32'(i) * 32'h01010101 ^ 32'hA5A5A5A5;
      model_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5A5A5A5;
    end
    ram[4]    = 32'hDEADBEEF; model_mem[4]    = 32'hDEADBEEF;
    ram[1023] = 32'hCAFEF00D; model_mem[1023] = 32'hCAFEF00D;

    // Reset with a request pending: nothing may be granted.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    nxt(); nxt();
    #1;
    check("rst_gnt",     {30'd0, m0_gnt, m1_gnt}, 32'd0);
    check("rst_rvalid",  {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    nxt();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check("idle_nognt", {30'd0, m0_gnt, m1_gnt}, 32'd0);

    // Tie after reset: m0 store, m1 load, both held; grants m0, m1, m0.
    nxt();
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) nxt();
      #1;
      check($sformatf("tie_gnt0_c%0d", c), {31'd0, m0_gnt}, {31'd0, c == 0 || c == 6});
      check($sformatf("tie_gnt1_c%0d", c), {31'd0, m1_gnt}, {31'd0, c == 3});
      check($sformatf("tie_wr_c%0d", c),   {31'd0, mem_write}, {31'd0, c == 1 || c == 7});
      check($sformatf("tie_rd_c%0d", c),   {31'd0, mem_read},  {31'd0, c == 4});
      if (c == 0 || c == 6) push(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0);
      if (c == 3)           push(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    end
    nxt();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("tie_idle_nognt", {30'd0, m0_gnt, m1_gnt}, 32'd0);

    // Single load, misaligned store, range boundaries.
    txn(1'b0, 1'b0, 32'h10,  32'h0,      1'b0);
    txn(1'b1, 1'b1, 32'h22,  32'h55AA55AA, 1'b1);
    txn(1'b0, 1'b0, 32'hFFE, 32'h0,      1'b1);
    txn(1'b1, 1'b0, 32'hFFC, 32'h0,      1'b0);
    txn(1'b0, 1'b0, 32'h1000, 32'h0,     1'b1);
    txn(1'b1, 1'b1, 32'h40,  32'h0BADF00D, 1'b0);
    txn(1'b0, 1'b0, 32'h40,  32'h0,      1'b0);
    nxt();

    // Reset during ACCESS of an m0 store: write suppressed, no response.
    nxt();
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hBAD0BAD0);
    #1;
    check("ra_gnt", {31'd0, m0_gnt}, 32'd1);
    nxt();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    check("ra_write_suppressed", {31'd0, mem_write}, 32'd0);
    nxt();
    rst = 1'b0;
    #1;
    check("ra_no_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    check("ra_mem_addr_cleared", mem_addr, 32'h0);
    check("ra_ram_untouched", ram[12], model_mem[12]);

    // Next tie after the abort grants m0 again.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'hFFC, 32'h0);
    #1;
    check("ra_tie_gnt0", {31'd0, m0_gnt}, 32'd1);
    check("ra_tie_gnt1", {31'd0, m1_gnt}, 32'd0);
    push(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    nxt();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Drain: every queued response must have arrived within the budget.
    for (int i = 0; i < 10 && sb.size() != 0; i++) nxt();
    nxt();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL expose parameter ADDR_BYTES, default 4096, giving the data memory size in bytes.
REQ-002 The block SHALL have one clock and a synchronous active-high reset, ports as listed below.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 m0_req  input  1  requester 0 (CPU load/store) access request.
REQ-006 m0_we  input  1  requester 0 write enable (1=store, 0=load).
REQ-007 m0_addr  input  32  requester 0 byte address.
REQ-008 m0_wdata  input  32  requester 0 store data.
REQ-009 m0_gnt  output  1  request 0 accepted this cycle.
REQ-010 m0_rvalid  output  1  response 0 valid, one-cycle pulse.
REQ-011 m0_rdata  output  32  response 0 load data.
REQ-012 m0_err  output  1  response 0 error (misaligned or out of range), valid with m0_rvalid.
REQ-013 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same directions and widths as the m0 ports, for requester 1 (debug/loader).
REQ-014 mem_read  output  1  read strobe to data memory.
REQ-015 mem_write  output  1  write strobe to data memory.
REQ-016 mem_addr  output  32  address to data memory.
REQ-017 mem_wdata  output  32  write data to data memory.
REQ-018 mem_rdata  input  32  combinational read data from data memory.

Function
REQ-019 The FSM SHALL have three states, IDLE, ACCESS and RESP; every transaction takes exactly 3 cycles, IDLE to ACCESS to RESP to IDLE.
REQ-020 In IDLE with any req high, the block SHALL select one winner, assert that requester's gnt combinationally for that cycle only, register the winner's id, we, addr and wdata, and move to ACCESS.
REQ-021 In IDLE with no req high, all gnt SHALL be 0 and the state SHALL remain IDLE.
REQ-022 Arbitration SHALL be round-robin: with one requester, that requester wins; with both, the requester not served last wins.
REQ-023 The last-served pointer SHALL reset to 1, so m0 wins the first tie.
REQ-024 The last-served pointer SHALL update on the RESP-to-IDLE transition.
REQ-025 A request SHALL NOT be accepted outside IDLE; requesters hold req, we, addr and wdata until gnt.
REQ-026 In ACCESS, mem_addr and mem_wdata SHALL equal the latched values, mem_read SHALL equal !we and mem_write SHALL equal we, for exactly one cycle.
REQ-027 An access SHALL be erroneous if addr[1:0] != 0 or addr > ADDR_BYTES-4.
REQ-028 For an erroneous access, mem_read and mem_write SHALL both stay 0 and the error flag SHALL be latched.
REQ-029 At the end of ACCESS, mem_rdata SHALL be registered for loads; stores and erroneous accesses register 0.
REQ-030 In RESP, only the winner's rvalid SHALL be 1 for one cycle, with rdata and err from the registers.
REQ-031 The non-winner's rvalid, rdata and err SHALL be 0.
REQ-032 Outside ACCESS, mem_read and mem_write SHALL be 0.
REQ-033 Outside ACCESS, mem_addr and mem_wdata SHALL hold their last values.
REQ-034 A req arriving during ACCESS or RESP SHALL be served in the next IDLE cycle at the earliest.
REQ-035 Back-to-back transactions SHALL occur every 3 cycles.

Reset
REQ-036 While rst=1 at a clock edge, the state SHALL go to IDLE and the pointer to 1.
REQ-037 While rst=1, the latched registers, mem_addr and mem_wdata SHALL clear to 0.
REQ-038 While rst=1, all gnt, rvalid, err, mem_read and mem_write SHALL be 0.
REQ-039 Reset asserted in ACCESS or RESP SHALL abort the transaction: no rvalid is issued, and a write in ACCESS at that edge is suppressed because the strobe is forced to 0.

Verification
REQ-040 Single load: m0_req=1, m0_we=0, m0_addr=0x10, mem_rdata=0xDEADBEEF -> m0_gnt in cycle 0, mem_read=1 with mem_addr=0x10 in cycle 1, m0_rvalid=1 with m0_rdata=0xDEADBEEF and m0_err=0 in cycle 2.
REQ-041 Tie after reset: both req held, m0 store and m1 load -> grant order m0, m1, m0, spaced 3 cycles apart; m1_rvalid never coincides with m0_rvalid.
REQ-042 Misaligned: m1_addr=0x22, m1_we=1 -> mem_write stays 0, then m1_rvalid=1 with m1_err=1 and m1_rdata=0.
REQ-043 Out of range: m0_addr=0xFFE (ADDR_BYTES=4096), load -> no mem_read strobe, m0_err=1.
REQ-044 Reset mid-access: rst=1 during ACCESS of an m0 store -> mem_write=0 at that edge, no m0_rvalid, IDLE on the next cycle, and the next tie grants m0.
